// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer (main drives decode, skid holds overflow); optional stats via IFID_STATS_EN.
// Latency: an entry accepted at an edge is visible on out_* right after that edge; 1 instr/cycle while out_ready=1.
// Backpressure: in_ready is registered and drops only when both entries are full; flush empties the buffer.
module if_id_skid_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instn,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_nextpc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instn,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_nextpc
`ifdef IFID_STATS_EN
    ,
    output logic [31:0]       fetched_cnt,
    output logic [31:0]       flushed_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] instn;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] nextpc;
    } ent_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam ent_t EMPTY_ENT = '{instn: NOP_INSTR, pc: '0, nextpc: '0};

    state_t state_q, state_nxt;
    ent_t   main_q, main_nxt;
    ent_t   skid_q, skid_nxt;
    ent_t   in_ent;
    logic   in_ready_q;
    logic   accept;
    logic   deliver;

    assign in_ent    = '{instn: in_instn, pc: in_pc, nextpc: in_nextpc};
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign deliver   = out_valid & out_ready;

    assign out_instn  = main_q.instn;
    assign out_pc     = main_q.pc;
    assign out_nextpc = main_q.nextpc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_q     <= EMPTY_ENT;
            skid_q     <= EMPTY_ENT;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    always_comb begin
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // Flush wins over accept and deliver; anything accepted this cycle is dropped.
            state_nxt = EMPTY;
            main_nxt  = EMPTY_ENT;
            skid_nxt  = EMPTY_ENT;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        main_nxt  = in_ent;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_nxt = in_ent;
                    end else if (accept) begin
                        state_nxt = TWO;
                        skid_nxt  = in_ent;
                    end else if (deliver) begin
                        state_nxt = EMPTY;
                        main_nxt  = EMPTY_ENT;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = EMPTY_ENT;
                end
            endcase
        end
    end

`ifdef IFID_STATS_EN
    logic [1:0] held;

    assign held = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;

    // An entry handed to decode in the flush cycle counts as fetched, not flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            if (deliver) begin
                fetched_cnt <= fetched_cnt + 32'd1;
            end
            if (flush) begin
                flushed_cnt <= flushed_cnt + 32'(held - {1'b0, deliver});
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios then random traffic against a queue-based reference model.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instn;
    logic [31:0] in_pc;
    logic [31:0] in_nextpc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instn;
    logic [31:0] out_pc;
    logic [31:0] out_nextpc;
`ifdef IFID_STATS_EN
    logic [31:0] fetched_cnt;
    logic [31:0] flushed_cnt;
`endif

    if_id_skid_reg #(.DATA_W(32), .NOP_INSTR(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instn   (in_instn),
        .in_pc      (in_pc),
        .in_nextpc  (in_nextpc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instn  (out_instn),
        .out_pc     (out_pc),
        .out_nextpc (out_nextpc)
`ifdef IFID_STATS_EN
        ,
        .fetched_cnt(fetched_cnt),
        .flushed_cnt(flushed_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of {instn, pc, nextpc} with capacity 2.
    logic [95:0] q[$];
    int unsigned m_fetched;
    int unsigned m_flushed;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_outputs();
        logic [95:0] e;
        e = (q.size() > 0) ? q[0] : 96'h0;
        chk("out_valid",  32'(out_valid), 32'(q.size() > 0));
        chk("in_ready",   32'(in_ready),  32'(q.size() < 2));
        chk("out_instn",  out_instn,  e[95:64]);
        chk("out_pc",     out_pc,     e[63:32]);
        chk("out_nextpc", out_nextpc, e[31:0]);
`ifdef IFID_STATS_EN
        chk("fetched_cnt", fetched_cnt, m_fetched);
        chk("flushed_cnt", flushed_cnt, m_flushed);
`endif
    endtask

    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] npc, input logic ordy, input logic fl);
        int n;
        bit acc;
        bit dlv;
        in_valid  = iv;
        in_instn  = ins;
        in_pc     = pc;
        in_nextpc = npc;
        out_ready = ordy;
        flush     = fl;
        n   = q.size();
        acc = iv && (n < 2);
        dlv = ordy && (n > 0);
        @(posedge clk);
        if (dlv) m_fetched++;
        if (fl) begin
            m_flushed += n - int'(dlv);
            q.delete();
        end else begin
            if (dlv) void'(q.pop_front());
            if (acc) q.push_back({ins, pc, npc});
        end
        #1;
        check_outputs();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; m_fetched = 0; m_flushed = 0;
        reset = 1'b1; in_valid = 1'b0; in_instn = '0; in_pc = '0; in_nextpc = '0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        check_outputs();
        reset = 1'b0;

        // Streaming, then stats scenario: 9 delivered, one flushed.
        step(1'b1, 32'h20080005, 32'd0, 32'd4, 1'b1, 1'b0);
        chk("stream0_instn", out_instn, 32'h20080005);
        chk("stream0_nextpc", out_nextpc, 32'd4);
        step(1'b1, 32'h20090003, 32'd4, 32'd8, 1'b1, 1'b0);
        chk("stream1_instn", out_instn, 32'h20090003);
        chk("stream1_nextpc", out_nextpc, 32'd8);
        chk("stream_in_ready", 32'(in_ready), 32'd1);
        for (int i = 2; i < 9; i++) step(1'b1, $urandom, 32'(4 * i), 32'(4 * i + 4), 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h1234_5678, 32'd36, 32'd40, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef IFID_STATS_EN
        chk("stats_fetched9", fetched_cnt, 32'd9);
        chk("stats_flushed1", flushed_cnt, 32'd1);
`endif

        // Stall fill and release in order.
        step(1'b1, 32'hA000_0000, 32'd0, 32'd4, 1'b0, 1'b0);
        step(1'b1, 32'hA000_0004, 32'd4, 32'd8, 1'b0, 1'b0);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 32'hA000_0008, 32'd8, 32'd12, 1'b0, 1'b0);
        chk("fill_held_pc", out_pc, 32'd0);
        step(1'b1, 32'hA000_0008, 32'd8, 32'd12, 1'b1, 1'b0);
        chk("drain_pc4", out_pc, 32'd4);
        step(1'b1, 32'hA000_0008, 32'd8, 32'd12, 1'b1, 1'b0);
        chk("drain_pc8", out_pc, 32'd8);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Stall stability at pc 12.
        step(1'b1, 32'hC0DE_000C, 32'd12, 32'd16, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, $urandom, $urandom, $urandom, 1'b0, 1'b0);
            chk("stall_instn", out_instn, 32'hC0DE_000C);
            chk("stall_pc", out_pc, 32'd12);
            chk("stall_nextpc", out_nextpc, 32'd16);
        end

        // Flush in TWO while fetch tries to push.
        step(1'b1, 32'hC0DE_0010, 32'd16, 32'd20, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 32'd20, 32'd24, 1'b0, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_instn", out_instn, 32'h0);
`ifdef IFID_STATS_EN
        chk("flush_two_cnt", flushed_cnt, 32'd3);
`endif

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

        // Asynchronous reset while in TWO.
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h1111_1111, 32'h100, 32'h104, 1'b0, 1'b0);
        step(1'b1, 32'h2222_2222, 32'h104, 32'h108, 1'b0, 1'b0);
        chk("pre_reset_two", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        q.delete(); m_fetched = 0; m_flushed = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instn", out_instn, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        check_outputs();
        #1;
        reset = 1'b0;
        step(1'b1, 32'h3333_3333, 32'h200, 32'h204, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
